// File: rtl/io_pkg.sv
// Shared definitions for the I/O handshake responder.
// Contents:
//   io_state_e      - responder FSM states
//   IO_WIDTH_DEF    - default I/O word width
//   FIFO_DEPTH_DEF  - default FIFO depth
//   cnt_width()     - occupancy counter width for a FIFO of a given depth
package io_pkg;

  typedef enum logic [2:0] {
    IO_IDLE,
    IO_IN_SETUP,
    IO_IN_ACK,
    IO_OUT_ACK,
    IO_RELEASE
  } io_state_e;

  localparam int IO_WIDTH_DEF   = 16;
  localparam int FIFO_DEPTH_DEF = 8;

  // A count must reach DEPTH itself, so it needs one bit more than a pointer.
  function automatic int cnt_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/io_handshake_responder_if.sv
// Processor-side human-interface handshake bundle.
// Signals:
//   is_input     - processor waits for an input word
//   is_output    - processor presents an output word
//   out_data     - word displayed by the processor
//   in_data      - word presented to the processor in place of switches
//   confirmation - one-cycle acknowledge to the control unit
// Modports: master = processor side, slave = responder side.
interface io_handshake_responder_if
  import io_pkg::*;
#(
  parameter int IO_WIDTH = IO_WIDTH_DEF
);
  logic                is_input;
  logic                is_output;
  logic [IO_WIDTH-1:0] out_data;
  logic [IO_WIDTH-1:0] in_data;
  logic                confirmation;

  modport master (
    output is_input, is_output, out_data,
    input  in_data, confirmation
  );

  modport slave (
    input  is_input, is_output, out_data,
    output in_data, confirmation
  );
endinterface

// File: rtl/io_sync_fifo.sv
// Single-clock show-ahead FIFO with full/empty flags and occupancy count.
// Ports:
//   clk, rst     - clock, synchronous active-high reset (pointers/count only)
//   i_push       - write request, ignored while full
//   i_push_data  - write data
//   i_pop        - read request, ignored while empty
//   o_head       - current head word (meaningless while empty)
//   o_full       - DEPTH entries held
//   o_empty      - no entries held
//   o_count      - occupancy 0..DEPTH
module io_sync_fifo
  import io_pkg::*;
#(
  parameter  int WIDTH = IO_WIDTH_DEF,
  parameter  int DEPTH = FIFO_DEPTH_DEF,
  localparam int CW    = cnt_width(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_push_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_head,
  output logic             o_full,
  output logic             o_empty,
  output logic [CW-1:0]    o_count
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             w_push;
  logic             w_pop;

  assign o_full  = (r_count == CW'(DEPTH));
  assign o_empty = (r_count == '0);
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;
  assign o_head  = r_mem[r_rd_ptr];
  assign o_count = r_count;

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_push_data;
  end

  // DEPTH is a power of two, so the pointers wrap by natural overflow.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end
endmodule

// File: rtl/io_handshake_responder.sv
// Peripheral-side peer of the processor's I/O handshake. Input requests are
// answered from a host-loaded input FIFO, output requests are captured into
// a host-drained output FIFO, and a one-cycle confirmation is generated.
// Optional feature macro: IO_TIMEOUT_EN (starvation timeout on input).
// Ports:
//   slow_clock, reset   - processor clock, synchronous active-high reset
//   io (slave)          - is_input/is_output/out_data in, in_data/confirmation out
//   push_valid/_data/_ready - host side of the input FIFO
//   pop_valid/_data/_ready  - host side of the output FIFO (show-ahead)
//   in_count, out_count - FIFO occupancies
//   timeout_flag        - sticky starvation flag (0 without IO_TIMEOUT_EN)
module io_handshake_responder
  import io_pkg::*;
#(
  parameter  int IO_WIDTH       = IO_WIDTH_DEF,
  parameter  int FIFO_DEPTH     = FIFO_DEPTH_DEF,
  parameter  int SETUP_CYCLES   = 2,
  parameter  int TIMEOUT_CYCLES = 1024,
  localparam int CW             = cnt_width(FIFO_DEPTH)
) (
  input  logic                slow_clock,
  input  logic                reset,
  io_handshake_responder_if.slave io,
  input  logic                push_valid,
  input  logic [IO_WIDTH-1:0] push_data,
  output logic                push_ready,
  output logic                pop_valid,
  output logic [IO_WIDTH-1:0] pop_data,
  input  logic                pop_ready,
  output logic [CW-1:0]       in_count,
  output logic [CW-1:0]       out_count,
  output logic                timeout_flag
);
  localparam int SW = (SETUP_CYCLES > 1) ? $clog2(SETUP_CYCLES) : 1;

  io_state_e           r_state, w_state_nxt;
  logic [SW-1:0]       r_cnt, w_cnt_nxt;
  logic [IO_WIDTH-1:0] r_in_data, w_in_data_nxt;
  logic                w_in_pop, w_out_push;
  logic                w_in_full, w_in_empty, w_out_full, w_out_empty;
  logic [IO_WIDTH-1:0] w_in_head;

  io_sync_fifo #(.WIDTH(IO_WIDTH), .DEPTH(FIFO_DEPTH)) u_in_fifo (
    .clk(slow_clock), .rst(reset),
    .i_push(push_valid), .i_push_data(push_data), .i_pop(w_in_pop),
    .o_head(w_in_head), .o_full(w_in_full), .o_empty(w_in_empty),
    .o_count(in_count)
  );

  io_sync_fifo #(.WIDTH(IO_WIDTH), .DEPTH(FIFO_DEPTH)) u_out_fifo (
    .clk(slow_clock), .rst(reset),
    .i_push(w_out_push), .i_push_data(io.out_data), .i_pop(pop_ready),
    .o_head(pop_data), .o_full(w_out_full), .o_empty(w_out_empty),
    .o_count(out_count)
  );

  assign push_ready      = !w_in_full;
  assign pop_valid       = !w_out_empty;
  assign io.in_data      = r_in_data;
  assign io.confirmation = (r_state == IO_IN_ACK) || (r_state == IO_OUT_ACK);

`ifdef IO_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] r_starve, w_starve_nxt;
  logic          r_timeout, w_timeout_nxt;
  assign timeout_flag = r_timeout;
`else
  // TIMEOUT_CYCLES has no effect in this build; starvation waits forever.
  logic w_unused_timeout;
  assign w_unused_timeout = (TIMEOUT_CYCLES > 0);
  assign timeout_flag     = 1'b0;
`endif

  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_in_data_nxt = r_in_data;
    w_in_pop      = 1'b0;
    w_out_push    = 1'b0;
`ifdef IO_TIMEOUT_EN
    w_starve_nxt  = r_starve;
    w_timeout_nxt = r_timeout;
`endif
    case (r_state)
      IO_IDLE: begin
        // Input has priority; a blocked request just keeps polling here.
        if (io.is_input && !w_in_empty) begin
          w_in_data_nxt = w_in_head;
          w_in_pop      = 1'b1;
          w_cnt_nxt     = SW'(SETUP_CYCLES - 1);
          w_state_nxt   = IO_IN_SETUP;
        end else if (io.is_output && !w_out_full) begin
          w_out_push    = 1'b1;
          w_state_nxt   = IO_OUT_ACK;
        end
`ifdef IO_TIMEOUT_EN
        else if (io.is_input) begin
          if (r_starve == TW'(TIMEOUT_CYCLES - 1)) begin
            w_in_data_nxt = '0;
            w_timeout_nxt = 1'b1;
            w_state_nxt   = IO_IN_ACK;
          end else begin
            w_starve_nxt  = r_starve + TW'(1);
          end
        end
`endif
      end
      IO_IN_SETUP: begin
        if (r_cnt == '0) w_state_nxt = IO_IN_ACK;
        else             w_cnt_nxt   = r_cnt - SW'(1);
      end
      IO_IN_ACK, IO_OUT_ACK: w_state_nxt = IO_RELEASE;
      // Waiting for both requests to drop keeps one request to one word.
      IO_RELEASE: begin
        if (!io.is_input && !io.is_output) w_state_nxt = IO_IDLE;
      end
      default: w_state_nxt = IO_IDLE;
    endcase
`ifdef IO_TIMEOUT_EN
    if (w_state_nxt != IO_IDLE) w_starve_nxt = '0;
`endif
  end

  always_ff @(posedge slow_clock) begin
    if (reset) begin
      r_state   <= IO_IDLE;
      r_cnt     <= '0;
      r_in_data <= '0;
`ifdef IO_TIMEOUT_EN
      r_starve  <= '0;
      r_timeout <= 1'b0;
`endif
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_in_data <= w_in_data_nxt;
`ifdef IO_TIMEOUT_EN
      r_starve  <= w_starve_nxt;
      r_timeout <= w_timeout_nxt;
`endif
    end
  end
endmodule

// File: tb/tb_io_handshake_responder.sv
// Self-checking bench for io_handshake_responder (IO_WIDTH=16, FIFO_DEPTH=8,
// SETUP_CYCLES=2, TIMEOUT_CYCLES=16). A transaction-level model (queues plus
// a countdown to the expected confirmation) is compared every cycle; directed
// literal checks pin the model's timing and data.
module tb_io_handshake_responder;
  localparam int W     = 16;
  localparam int DEPTH = 8;
  localparam int SETUP = 2;
  localparam int TMO   = 16;

  logic         slow_clock;
  logic         reset;
  logic         push_valid;
  logic [W-1:0] push_data;
  logic         push_ready;
  logic         pop_valid;
  logic [W-1:0] pop_data;
  logic         pop_ready;
  logic [3:0]   in_count;
  logic [3:0]   out_count;
  logic         timeout_flag;

  io_handshake_responder_if #(.IO_WIDTH(W)) bus ();

  io_handshake_responder #(
    .IO_WIDTH(W), .FIFO_DEPTH(DEPTH), .SETUP_CYCLES(SETUP), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .slow_clock(slow_clock), .reset(reset), .io(bus),
    .push_valid(push_valid), .push_data(push_data), .push_ready(push_ready),
    .pop_valid(pop_valid), .pop_data(pop_data), .pop_ready(pop_ready),
    .in_count(in_count), .out_count(out_count), .timeout_flag(timeout_flag)
  );

  initial begin
    slow_clock = 1'b0;
    forever #5 slow_clock = ~slow_clock;
  end

  int n_checks   = 0;
  int n_failures = 0;

  // Model state
  logic [W-1:0] m_inq[$];
  logic [W-1:0] m_outq[$];
  logic [W-1:0] m_in_data;
  int           m_wait;     // edges until confirmation; -1 = none pending
  bit           m_hold;     // acknowledged, waiting for requests to drop
  bit           m_tmo;
  int           m_starve;
  bit           m_en = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Compare DUT against model, then advance the model by the coming edge.
  task automatic model_step();
    bit in_empty, out_full, fsm_pop, fsm_push, h_push, h_pop;
    if (m_en) begin
      chk("in_data",      bus.in_data,      m_in_data);
      chk("confirmation", bus.confirmation, (m_wait == 0));
      chk("push_ready",   push_ready,       (m_inq.size() < DEPTH));
      chk("pop_valid",    pop_valid,        (m_outq.size() > 0));
      chk("in_count",     in_count,         m_inq.size());
      chk("out_count",    out_count,        m_outq.size());
      chk("timeout_flag", timeout_flag,     m_tmo);
      if (m_outq.size() > 0) chk("pop_data", pop_data, m_outq[0]);
    end
    if (reset) begin
      m_inq.delete();
      m_outq.delete();
      m_in_data = '0;
      m_wait    = -1;
      m_hold    = 1'b0;
      m_tmo     = 1'b0;
      m_starve  = 0;
      m_en      = 1'b1;
    end else begin
      in_empty = (m_inq.size() == 0);
      out_full = (m_outq.size() == DEPTH);
      h_push   = push_valid && (m_inq.size() < DEPTH);
      h_pop    = pop_ready && (m_outq.size() > 0);
      fsm_pop  = 1'b0;
      fsm_push = 1'b0;
      if (m_wait == 0) begin
        m_wait = -1;
        m_hold = 1'b1;
      end else if (m_wait > 0) begin
        m_wait--;
      end else if (m_hold) begin
        if (!bus.is_input && !bus.is_output) m_hold = 1'b0;
      end else if (bus.is_input && !in_empty) begin
        m_in_data = m_inq[0];
        fsm_pop   = 1'b1;
        m_wait    = SETUP;
        m_starve  = 0;
      end else if (bus.is_output && !out_full) begin
        fsm_push  = 1'b1;
        m_wait    = 0;
        m_starve  = 0;
      end
`ifdef IO_TIMEOUT_EN
      else if (bus.is_input) begin
        m_starve++;
        if (m_starve == TMO) begin
          m_in_data = '0;
          m_tmo     = 1'b1;
          m_wait    = 0;
          m_starve  = 0;
        end
      end
`endif
      if (fsm_pop)  void'(m_inq.pop_front());
      if (h_push)   m_inq.push_back(push_data);
      if (h_pop)    void'(m_outq.pop_front());
      if (fsm_push) m_outq.push_back(bus.out_data);
    end
  endtask

  task automatic tick();
    @(negedge slow_clock);
    model_step();
    @(posedge slow_clock);
    #1;
  endtask

  task automatic wait_conf(input string nm, input int lim, input int exp_n);
    int n = 0;
    while (bus.confirmation !== 1'b1 && n < lim) begin
      tick();
      n++;
    end
    chk(nm, n, exp_n);
  endtask

  task automatic release_req();
    bus.is_input  = 1'b0;
    bus.is_output = 1'b0;
    tick();
    tick();
  endtask

  task automatic push_word(input logic [W-1:0] w);
    push_valid = 1'b1;
    push_data  = w;
    tick();
    push_valid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=running expected=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset         = 1'b1;
    push_valid    = 1'b0;
    push_data     = '0;
    pop_ready     = 1'b0;
    bus.is_input  = 1'b0;
    bus.is_output = 1'b0;
    bus.out_data  = '0;
    tick();
    tick();
    reset = 1'b0;
    chk("rst_in_count", in_count, 0);
    chk("rst_out_count", out_count, 0);
    chk("rst_in_data", bus.in_data, 0);
    chk("rst_conf", bus.confirmation, 0);
    chk("rst_push_ready", push_ready, 1);
    chk("rst_pop_valid", pop_valid, 0);
    chk("rst_timeout", timeout_flag, 0);
    tick();

    // Input path
    push_word(16'h00A5);
    push_word(16'h1234);
    chk("in_cnt2", in_count, 2);
    bus.is_input = 1'b1;
    wait_conf("in_lat1", 10, SETUP + 1);
    chk("in_word1", bus.in_data, 16'h00A5);
    chk("in_cnt1", in_count, 1);
    release_req();
    bus.is_input = 1'b1;
    wait_conf("in_lat2", 10, SETUP + 1);
    chk("in_word2", bus.in_data, 16'h1234);
    chk("in_cnt0", in_count, 0);
    release_req();

    // Output path
    bus.out_data  = 16'hBEEF;
    bus.is_output = 1'b1;
    wait_conf("out_lat", 10, 1);
    chk("out_valid", pop_valid, 1);
    chk("out_word", pop_data, 16'hBEEF);
    bus.is_output = 1'b0;
    pop_ready     = 1'b1;
    tick();
    pop_ready = 1'b0;
    chk("out_drained", out_count, 0);
    tick();

    // Input FIFO full: ninth push ignored
    for (int i = 0; i < 9; i++) begin
      push_valid = 1'b1;
      push_data  = 16'h1000 + 16'(i);
      tick();
    end
    push_valid = 1'b0;
    chk("in_full_ready", push_ready, 0);
    chk("in_full_cnt", in_count, 8);
    for (int k = 0; k < 8; k++) begin
      bus.is_input = 1'b1;
      wait_conf("drain_lat", 10, SETUP + 1);
      chk("drain_word", bus.in_data, 32'h1000 + k);
      release_req();
    end
    chk("in_empty_again", in_count, 0);

    // Output FIFO full: request blocked until the host pops
    for (int k = 0; k < 8; k++) begin
      bus.out_data  = 16'h00C0 + 16'(k);
      bus.is_output = 1'b1;
      wait_conf("fill_lat", 10, 1);
      release_req();
    end
    chk("out_full_cnt", out_count, 8);
    bus.out_data  = 16'hD00D;
    bus.is_output = 1'b1;
    for (int k = 0; k < 5; k++) tick();
    chk("out_blocked_conf", bus.confirmation, 0);
    chk("out_blocked_head", pop_data, 16'h00C0);
    pop_ready = 1'b1;
    tick();
    pop_ready = 1'b0;
    wait_conf("out_unblock_lat", 10, 1);
    chk("out_refill_cnt", out_count, 8);
    release_req();
    pop_ready = 1'b1;
    for (int k = 0; k < 8; k++) tick();
    pop_ready = 1'b0;
    chk("out_drain_cnt", out_count, 0);

    // Simultaneous requests: input first, output after a fresh IDLE
    push_word(16'h5A5A);
    bus.out_data  = 16'h7777;
    bus.is_input  = 1'b1;
    bus.is_output = 1'b1;
    wait_conf("both_lat", 10, SETUP + 1);
    chk("both_in_word", bus.in_data, 16'h5A5A);
    chk("both_out_none", out_count, 0);
    bus.is_input = 1'b0;
    for (int k = 0; k < 3; k++) tick();
    chk("both_out_still_none", out_count, 0);
    release_req();
    bus.is_output = 1'b1;
    wait_conf("both_out_lat", 10, 1);
    chk("both_out_word", pop_data, 16'h7777);
    release_req();
    pop_ready = 1'b1;
    tick();
    pop_ready = 1'b0;

    // Held request consumes one word; reset during setup
    push_word(16'h0101);
    push_word(16'h0202);
    push_word(16'h0303);
    bus.is_input = 1'b1;
    wait_conf("held_lat", 10, SETUP + 1);
    for (int k = 0; k < 20; k++) tick();
    chk("held_cnt", in_count, 2);
    chk("held_word", bus.in_data, 16'h0101);
    release_req();
    bus.is_input = 1'b1;
    tick();
    chk("setup_word", bus.in_data, 16'h0202);
    chk("setup_cnt", in_count, 1);
    reset        = 1'b1;
    bus.is_input = 1'b0;
    tick();
    reset = 1'b0;
    chk("midrst_cnt", in_count, 0);
    chk("midrst_in_data", bus.in_data, 0);
    chk("midrst_conf", bus.confirmation, 0);
    for (int k = 0; k < 4; k++) tick();
    chk("midrst_conf_later", bus.confirmation, 0);

`ifdef IO_TIMEOUT_EN
    // Starvation timeout
    bus.is_input = 1'b1;
    wait_conf("tmo_lat", 40, TMO);
    chk("tmo_in_data", bus.in_data, 0);
    chk("tmo_flag", timeout_flag, 1);
    release_req();
    for (int k = 0; k < 5; k++) tick();
    chk("tmo_sticky", timeout_flag, 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("tmo_cleared", timeout_flag, 0);
`else
    // Starvation waits indefinitely, then a late word is served
    bus.is_input = 1'b1;
    for (int k = 0; k < 40; k++) tick();
    chk("starve_conf", bus.confirmation, 0);
    chk("starve_flag", timeout_flag, 0);
    push_word(16'h4242);
    wait_conf("starve_lat", 10, SETUP + 1);
    chk("starve_word", bus.in_data, 16'h4242);
    release_req();
`endif
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_failures);
    $finish;
  end
endmodule
